// File: rtl/ddc_frame_buf_pkg.sv
// Shared constants and types for the DDC ping-pong frame buffer.
package ddc_frame_buf_pkg;

  localparam int DEPTH  = 512;
  localparam int DROP_W = 16;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } wr_state_e;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] val);
    return (val == {DROP_W{1'b1}}) ? val : val + {{(DROP_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ddc_frame_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds when idle.
module sdp_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Storage array write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; only the output register is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/ddc_frame_buf.sv
// Ping-pong frame buffer: the writer fills 512-sample banks of DDC I/Q while the reader drains the other.
module ddc_frame_buf
  import ddc_frame_buf_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_i,
  input  logic [DW-1:0]     in_q,
  output logic              in_ready,
  output logic              frame_ready,
  output logic              frame_avail,
  output logic              rd_bank,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [2*DW-1:0]   rd_data,
  output logic              rd_valid,
  input  logic              rd_done,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  wr_state_e         state_r;
  logic [AW-1:0]     wr_addr_r;
  logic              wr_bank_r;
  logic              rd_bank_r;
  logic [1:0]        bank_full_r;
  logic              frame_ready_r;
  logic              rd_valid_r;
  logic              overflow_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic              wr_en_s;
  logic              wrap_s;
  logic              clear_s;
  logic              drop_s;
  logic [1:0]        set_mask_s;
  logic [1:0]        clr_mask_s;
  logic [1:0]        bank_full_nx_s;

  assign wr_en_s = in_valid && (state_r == FILL);
  assign drop_s  = in_valid && (state_r == STALL);
  assign wrap_s  = wr_en_s && (wr_addr_r == AW'(DEPTH - 1));
  assign clear_s = rd_done && bank_full_r[rd_bank_r];

  // Bank completion and reader release hit different banks, so they combine as independent masks.
  always_comb begin
    set_mask_s     = wrap_s  ? (2'b01 << wr_bank_r) : 2'b00;
    clr_mask_s     = clear_s ? (2'b01 << rd_bank_r) : 2'b00;
    bank_full_nx_s = (bank_full_r | set_mask_s) & ~clr_mask_s;
  end

  // Writer FSM, bank bookkeeping, read qualification and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FILL;
      wr_addr_r     <= '0;
      wr_bank_r     <= 1'b0;
      rd_bank_r     <= 1'b0;
      bank_full_r   <= 2'b00;
      frame_ready_r <= 1'b0;
      rd_valid_r    <= 1'b0;
      overflow_r    <= 1'b0;
      drop_cnt_r    <= '0;
    end else begin
      bank_full_r   <= bank_full_nx_s;
      frame_ready_r <= wrap_s;
      rd_valid_r    <= rd_en;
      if (wr_en_s) begin
        wr_addr_r <= wrap_s ? '0 : wr_addr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (wrap_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
      if (clear_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end
      // Stall releases only once the clear is registered, so the clearing cycle's sample is lost.
      case (state_r)
        FILL:    if (wrap_s && bank_full_nx_s[~wr_bank_r]) state_r <= STALL;
        STALL:   if (!bank_full_nx_s[wr_bank_r]) state_r <= FILL;
        default: state_r <= FILL;
      endcase
    end
  end

  sdp_ram #(
    .DW (2*DW),
    .AW (AW+1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en_s),
    .waddr ({wr_bank_r, wr_addr_r}),
    .wdata ({in_i, in_q}),
    .re    (rd_en),
    .raddr ({rd_bank_r, rd_addr}),
    .rdata (rd_data)
  );

  assign in_ready    = (state_r == FILL);
  assign frame_ready = frame_ready_r;
  assign frame_avail = bank_full_r[rd_bank_r];
  assign rd_bank     = rd_bank_r;
  assign rd_valid    = rd_valid_r;
  assign overflow    = overflow_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_ddc_frame_buf.sv
// Randomized bench for ddc_frame_buf against a queue-of-frames reference model.
module tb_ddc_frame_buf;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int N  = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_i = '0;
  logic [DW-1:0]   in_q = '0;
  logic            in_ready;
  logic            frame_ready;
  logic            frame_avail;
  logic            rd_bank;
  logic            rd_en = 1'b0;
  logic [AW-1:0]   rd_addr = '0;
  logic [2*DW-1:0] rd_data;
  logic            rd_valid;
  logic            rd_done = 1'b0;
  logic            overflow;
  logic [15:0]     drop_cnt;

  always #5 clk = ~clk;

  ddc_frame_buf #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
    .in_ready(in_ready), .frame_ready(frame_ready), .frame_avail(frame_avail),
    .rd_bank(rd_bank), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_done(rd_done), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: expected RAM image plus a FIFO of completed frames (bank ids in write order).
  logic [2*DW-1:0] mem_m [2][N];
  bit              known_m [2][N];
  int              full_q [$];
  int              wa_m, wb_m, rb_m, dcnt_m;
  bit              ovf_m, fr_m, rv_m, rdd_known;
  logic [2*DW-1:0] rdd_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    full_q.delete();
    wa_m = 0; wb_m = 0; rb_m = 0; dcnt_m = 0;
    ovf_m = 1'b0; fr_m = 1'b0; rv_m = 1'b0;
    rdd_m = '0; rdd_known = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_ready", frame_ready, 0);
    check("rst_frame_avail", frame_avail, 0);
    check("rst_rd_bank", rd_bank, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
  endtask

  // One clock: drive inputs, advance model, then compare every output.
  task automatic step(input bit v, input logic [DW-1:0] i, input logic [DW-1:0] q,
                      input bit ren, input logic [AW-1:0] ra, input bit done);
    int pre;
    bit acc;
    in_valid = v; in_i = i; in_q = q; rd_en = ren; rd_addr = ra; rd_done = done;
    pre = full_q.size();
    check("in_ready", in_ready, (pre < 2) ? 1 : 0);
    acc = v && (pre < 2);
    rv_m = ren;
    if (ren) begin
      rdd_m = mem_m[rb_m][ra];
      rdd_known = known_m[rb_m][ra] && !(acc && wb_m == rb_m && wa_m == int'(ra));
    end
    fr_m = 1'b0;
    if (acc) begin
      mem_m[wb_m][wa_m] = {i, q};
      known_m[wb_m][wa_m] = 1'b1;
      wa_m++;
      if (wa_m == N) begin
        wa_m = 0;
        full_q.push_back(wb_m);
        wb_m ^= 1;
        fr_m = 1'b1;
      end
    end else if (v) begin
      ovf_m = 1'b1;
      if (dcnt_m < 65535) dcnt_m++;
    end
    if (done && pre > 0) begin
      void'(full_q.pop_front());
      rb_m ^= 1;
    end
    @(posedge clk); #1;
    check("frame_ready", frame_ready, fr_m);
    check("frame_avail", frame_avail, (full_q.size() > 0) ? 1 : 0);
    check("rd_bank", rd_bank, rb_m[0]);
    check("rd_valid", rd_valid, rv_m);
    check("overflow", overflow, ovf_m);
    check("drop_cnt", drop_cnt, dcnt_m);
    if (rdd_known) check("rd_data", rd_data, rdd_m);
  endtask

  task automatic send(input int count);
    for (int k = 0; k < count; k++) begin
      step(1'b1, DW'($urandom), DW'($urandom), 1'b0, '0, 1'b0);
    end
  endtask

  task automatic read_bank();
    for (int a = 0; a < N; a++) begin
      step(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
    end
  endtask

  initial begin
    int pulses;
    int k;
    logic [DW-1:0] n16;
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < N; a++) known_m[b][a] = 1'b0;
    end
    @(posedge clk); #1;
    do_reset();

    // Ramp frame into bank 0, then drain it.
    pulses = 0;
    for (int n = 0; n < N; n++) begin
      n16 = DW'(n);
      step(1'b1, n16, ~n16, 1'b0, '0, 1'b0);
      if (frame_ready) pulses++;
    end
    check("ramp_pulses", pulses, 1);
    check("ramp_avail", frame_avail, 1);
    check("ramp_rd_bank", rd_bank, 0);
    for (int a = 0; a < N; a++) begin
      n16 = DW'(a);
      step(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
      check("ramp_read", rd_data, {n16, ~n16});
    end
    step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    check("ramp_done_avail", frame_avail, 0);
    check("ramp_done_bank", rd_bank, 1);

    // Overflow, then resume on a random release cycle.
    do_reset();
    send(1536);
    check("ovf_flag", overflow, 1);
    check("ovf_drops", drop_cnt, 512);
    check("ovf_stall", in_ready, 0);
    k = $urandom_range(40, 5);
    send(k);
    step(1'b1, DW'($urandom), DW'($urandom), 1'b0, '0, 1'b1);
    check("resume_drop", drop_cnt, 512 + k + 1);
    check("resume_ready", in_ready, 1);
    send(600);
    read_bank();
    step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    read_bank();

    // Random mixed traffic.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, DW'($urandom), DW'($urandom), $urandom % 2 == 1,
           AW'($urandom), ($urandom % 200) == 0);
    end

    // Reset in the middle of a frame discards it.
    do_reset();
    send(300);
    do_reset();
    pulses = 0;
    for (int n = 0; n < N; n++) begin
      step(1'b1, DW'($urandom), DW'($urandom), 1'b0, '0, 1'b0);
      if (frame_ready) pulses++;
    end
    check("midrst_pulses", pulses, 1);
    read_bank();
    check("midrst_ovf", overflow, 0);

    // Drop counter saturation.
    do_reset();
    send(1024 + 65534);
    check("sat_fffe", drop_cnt, 16'hFFFE);
    send(3);
    check("sat_ffff", drop_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
